// File: rtl/fetch_instr_queue_pkg.sv
// Shared fetch-side types: the IFU output record and queue sizing defaults.
package fetch_instr_queue_pkg;

    localparam int INSTR_WIDTH    = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int FETCH_IQ_DEPTH = 8;

    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    // 98-bit record handed from fetch to dispatch, instr in the MSBs.
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        logic   is_cond_br;
        logic   br_dir_pred;
        addr_t  br_target_pred;
    } ifu_out_t;

endpackage

// File: rtl/fetch_instr_queue_if.sv
// Enqueue/dequeue handshake bundle between fetch, the instruction queue and dispatch.
interface fetch_instr_queue_if;
    import fetch_instr_queue_pkg::*;

    logic     enq_valid;
    logic     enq_ready;
    ifu_out_t enq_data;
    logic     deq_valid;
    logic     deq_ready;
    ifu_out_t deq_data;

    // master: the environment (IFU producer plus dispatch consumer)
    modport master (
        output enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data
    );

    // slave: the queue itself
    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data
    );

endinterface

// File: rtl/fetch_iq_ptr.sv
// Circular-buffer pointer with an extra wrap bit; counts modulo 2*DEPTH.
// Clear has priority over increment; both are synchronous, reset is asynchronous.
module fetch_iq_ptr
    import fetch_instr_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [$clog2(DEPTH):0]   ptr_o,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     wrap_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign idx_o  = ptr_q[AW-1:0];
    assign wrap_o = ptr_q[AW];

endmodule

// File: rtl/fetch_instr_queue.sv
// Fetch-to-dispatch instruction FIFO; 1-cycle enq->deq latency, 0-cycle with FETCH_IQ_BYPASS_EN.
// enq_ready drops only when full or flushing; flush empties the queue in one edge.
module fetch_instr_queue
    import fetch_instr_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_IQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   flush,
    fetch_instr_queue_if.slave     iq,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic          head_wrap;
    logic          tail_wrap;

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    ifu_out_t mem_q [DEPTH];

    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;
    logic bypass;
    logic bypass_take;
    logic wr_en;
    logic head_inc;

    fetch_iq_ptr #(.DEPTH(DEPTH)) u_head (
        .clk    (clk),
        .rst_aL (rst_aL),
        .clr_i  (flush),
        .inc_i  (head_inc),
        .ptr_o  (head_ptr),
        .idx_o  (head_idx),
        .wrap_o (head_wrap)
    );

    fetch_iq_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk    (clk),
        .rst_aL (rst_aL),
        .clr_i  (flush),
        .inc_i  (wr_en),
        .ptr_o  (tail_ptr),
        .idx_o  (tail_idx),
        .wrap_o (tail_wrap)
    );

    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);

`ifdef FETCH_IQ_BYPASS_EN
    // An entry arriving at an empty queue is offered to dispatch in the same cycle.
    assign bypass      = empty && iq.enq_valid && !flush;
    assign iq.deq_data = bypass ? iq.enq_data : mem_q[head_idx];
`else
    assign bypass      = 1'b0;
    assign iq.deq_data = mem_q[head_idx];
`endif

    assign iq.enq_ready = !full && !flush;
    assign iq.deq_valid = (!empty || bypass) && !flush;

    assign enq_fire    = iq.enq_valid && iq.enq_ready;
    assign deq_fire    = iq.deq_valid && iq.deq_ready;
    // A bypassed entry consumed on the spot never touches storage or pointers.
    assign bypass_take = bypass && iq.deq_ready;
    assign wr_en       = enq_fire && !bypass_take;
    assign head_inc    = deq_fire && !bypass_take;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({wr_en, head_inc})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset; deq_data is ignored while deq_valid is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_idx] <= iq.enq_data;
        end
    end

    assign count = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_aL)
        count_q <= PW'(DEPTH));

    a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_aL)
        count_q == PW'(tail_ptr - head_ptr));

    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_aL)
        !(wr_en && full));

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed table, corner sequences, then random traffic vs a queue model.
module tb_fetch_instr_queue;
    import fetch_instr_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          flush;
    logic [CW-1:0] count;

    fetch_instr_queue_if iq();

    fetch_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .flush  (flush),
        .iq     (iq),
        .count  (count)
    );

    always #5 clk = ~clk;

    int       nchk = 0;
    int       nerr = 0;
    ifu_out_t mq[$];

    typedef struct {
        logic          ev;
        logic          dr;
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [CW-1:0] e_cnt;
        logic          e_er;
        logic          chk_dv;
        logic          e_dv;
        logic [31:0]   e_pc;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ifu_out_t mk(input logic [31:0] instr, input logic [31:0] pc);
        ifu_out_t d;
        d.instr          = instr;
        d.pc             = pc;
        d.is_cond_br     = pc[2];
        d.br_dir_pred    = pc[3];
        d.br_target_pred = pc + 32'h40;
        return d;
    endfunction

    function automatic vec_t v(input logic ev, input logic dr, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [CW-1:0] e_cnt, input logic e_er,
                               input logic chk_dv, input logic e_dv, input logic [31:0] e_pc);
        vec_t r;
        r.ev = ev; r.dr = dr; r.instr = instr; r.pc = pc; r.e_cnt = e_cnt;
        r.e_er = e_er; r.chk_dv = chk_dv; r.e_dv = e_dv; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic drive(input logic f, input logic ev, input ifu_out_t d, input logic dr);
        flush        = f;
        iq.enq_valid = ev;
        iq.enq_data  = d;
        iq.deq_ready = dr;
    endtask

    // Model check at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit       byp, exp_dv, exp_er, dfire, efire;
        ifu_out_t exp_d;
        @(negedge clk);
        exp_er = (mq.size() < DEPTH) && !flush;
`ifdef FETCH_IQ_BYPASS_EN
        byp = (mq.size() == 0) && iq.enq_valid && !flush;
`else
        byp = 1'b0;
`endif
        exp_dv = !flush && (mq.size() != 0 || byp);
        exp_d  = (mq.size() != 0) ? mq[0] : iq.enq_data;
        chk("model enq_ready", 128'(iq.enq_ready), 128'(exp_er));
        chk("model deq_valid", 128'(iq.deq_valid), 128'(exp_dv));
        chk("model count", 128'(count), 128'(mq.size()));
        if (exp_dv) chk("model deq_data", 128'(iq.deq_data), 128'(exp_d));
        @(posedge clk);
        if (rst_aL) begin
            if (flush) begin
                mq.delete();
            end else begin
                dfire = exp_dv && iq.deq_ready;
                efire = iq.enq_valid && exp_er;
                if (!(byp && dfire)) begin
                    if (dfire) void'(mq.pop_front());
                    if (efire) mq.push_back(iq.enq_data);
                end
            end
        end
        #1;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, mk(32'h13 + i, base + 4 * i), 1'b0);
            tick();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, mk(0, 0), 1'b1);
            tick();
        end
    endtask

    initial begin
        ifu_out_t d9, db, dr_d;

        tbl[0] = v(1'b1, 1'b0, 32'hfe010113, 32'h1018c, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[1] = v(1'b1, 1'b0, 32'h00812e23, 32'h10190, 4'd1, 1'b1, 1'b1, 1'b1, 32'h1018c);
        tbl[2] = v(1'b1, 1'b0, 32'h00912c23, 32'h10194, 4'd2, 1'b1, 1'b1, 1'b1, 32'h1018c);
        tbl[3] = v(1'b0, 1'b1, 32'h0,        32'h0,     4'd3, 1'b1, 1'b1, 1'b1, 32'h1018c);
        tbl[4] = v(1'b0, 1'b1, 32'h0,        32'h0,     4'd2, 1'b1, 1'b1, 1'b1, 32'h10190);
        tbl[5] = v(1'b0, 1'b1, 32'h0,        32'h0,     4'd1, 1'b1, 1'b1, 1'b1, 32'h10194);
        tbl[6] = v(1'b0, 1'b0, 32'h0,        32'h0,     4'd0, 1'b1, 1'b1, 1'b0, 32'h0);

        rst_aL = 1'b0;
        drive(1'b0, 1'b0, mk(0, 0), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 128'(count), 128'(0));
        chk("reset deq_valid", 128'(iq.deq_valid), 128'(0));
        chk("reset enq_ready", 128'(iq.enq_ready), 128'(1));
        rst_aL = 1'b1;

        // In-order fill and drain
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, tbl[i].ev, mk(tbl[i].instr, tbl[i].pc), tbl[i].dr);
            #1;
            chk($sformatf("tbl%0d count", i), 128'(count), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d enq_ready", i), 128'(iq.enq_ready), 128'(tbl[i].e_er));
            if (tbl[i].chk_dv) begin
                chk($sformatf("tbl%0d deq_valid", i), 128'(iq.deq_valid), 128'(tbl[i].e_dv));
                if (tbl[i].e_dv) chk($sformatf("tbl%0d head pc", i), 128'(iq.deq_data.pc), 128'(tbl[i].e_pc));
            end
            tick();
        end

        // Full boundary
        fill(8, 32'h2000);
        d9 = mk(32'h99, 32'h2020);
        drive(1'b0, 1'b1, d9, 1'b0);
        #1;
        chk("full count", 128'(count), 128'(8));
        chk("full enq_ready", 128'(iq.enq_ready), 128'(0));
        tick();
        chk("full held count", 128'(count), 128'(8));
        chk("full head pc", 128'(iq.deq_data.pc), 128'(32'h2000));
        drive(1'b0, 1'b1, d9, 1'b1);
        #1;
        chk("full deq enq_ready", 128'(iq.enq_ready), 128'(0));
        tick();
        drive(1'b0, 1'b1, d9, 1'b0);
        #1;
        chk("after deq count", 128'(count), 128'(7));
        chk("after deq enq_ready", 128'(iq.enq_ready), 128'(1));
        chk("after deq head pc", 128'(iq.deq_data.pc), 128'(32'h2004));
        tick();
        chk("ninth accepted count", 128'(count), 128'(8));
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, mk(0, 0), 1'b1);
            #1;
            chk($sformatf("full drain pc%0d", i), 128'(iq.deq_data.pc), 128'(32'h2000 + 4 * i));
            tick();
        end

        // Simultaneous enq/deq at count 4, crossing the pointer wrap repeatedly
        fill(4, 32'h3000);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, mk(32'h33, 32'h3010 + 4 * i), 1'b1);
            #1;
            chk($sformatf("simul count%0d", i), 128'(count), 128'(4));
            chk($sformatf("simul pc%0d", i), 128'(iq.deq_data.pc), 128'(32'h3000 + 4 * i));
            tick();
        end
        drain(4);

        // Flush with enq and deq both presented
        fill(5, 32'h4000);
        drive(1'b1, 1'b1, mk(32'h55, 32'h5000), 1'b1);
        #1;
        chk("flush deq_valid", 128'(iq.deq_valid), 128'(0));
        chk("flush enq_ready", 128'(iq.enq_ready), 128'(0));
        chk("flush cycle count", 128'(count), 128'(5));
        tick();
        drive(1'b0, 1'b0, mk(0, 0), 1'b0);
        #1;
        chk("post flush count", 128'(count), 128'(0));
        chk("post flush deq_valid", 128'(iq.deq_valid), 128'(0));
        drive(1'b0, 1'b1, mk(32'h66, 32'h6000), 1'b0);
        tick();
        drive(1'b0, 1'b0, mk(0, 0), 1'b0);
        #1;
        chk("post flush new count", 128'(count), 128'(1));
        chk("post flush head pc", 128'(iq.deq_data.pc), 128'(32'h6000));
        drain(1);

        // Asynchronous reset between edges
        fill(6, 32'h7000);
        drive(1'b0, 1'b0, mk(0, 0), 1'b0);
        #1;
        chk("pre reset count", 128'(count), 128'(6));
        #1;
        rst_aL = 1'b0;
        mq.delete();
        #1;
        chk("async reset count", 128'(count), 128'(0));
        chk("async reset deq_valid", 128'(iq.deq_valid), 128'(0));
        chk("async reset enq_ready", 128'(iq.enq_ready), 128'(1));
        tick();
        rst_aL = 1'b1;
        tick();

        // Enqueue into an empty queue with dispatch ready
        db = mk(32'hb0b0b0b0, 32'h8000);
        drive(1'b0, 1'b1, db, 1'b1);
        #1;
`ifdef FETCH_IQ_BYPASS_EN
        chk("bypass deq_valid", 128'(iq.deq_valid), 128'(1));
        chk("bypass deq_data", 128'(iq.deq_data), 128'(db));
        tick();
        drive(1'b0, 1'b0, mk(0, 0), 1'b0);
        #1;
        chk("bypass count", 128'(count), 128'(0));
        chk("bypass after deq_valid", 128'(iq.deq_valid), 128'(0));
`else
        chk("nobypass deq_valid", 128'(iq.deq_valid), 128'(0));
        tick();
        drive(1'b0, 1'b0, mk(0, 0), 1'b1);
        #1;
        chk("nobypass next deq_valid", 128'(iq.deq_valid), 128'(1));
        chk("nobypass next deq_data", 128'(iq.deq_data), 128'(db));
        chk("nobypass count", 128'(count), 128'(1));
        tick();
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            dr_d.instr          = $urandom;
            dr_d.pc             = $urandom;
            dr_d.is_cond_br     = 1'($urandom_range(0, 1));
            dr_d.br_dir_pred    = 1'($urandom_range(0, 1));
            dr_d.br_target_pred = $urandom;
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), dr_d,
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
